// File: rtl/ex_stage_pipe.sv
// Execute stage with EX/MEM pipeline register: single-cycle ALU plus an iterative shift-add multiplier.
// Optional operand forwarding is enabled by defining EX_FORWARD_EN.
module ex_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEMC_W = 2,
    parameter int WBC_W  = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [3:0]        EXControlIn,
    input  logic [2:0]        FunctIn,
    input  logic [MEMC_W-1:0] MEMControlIn,
    input  logic [WBC_W-1:0]  WBControlIn,
    input  logic [DATA_W-1:0] DataAIn,
    input  logic [DATA_W-1:0] DataBIn,
    input  logic [DATA_W-1:0] SEIn,
    input  logic [REG_AW-1:0] RtIn,
    input  logic [REG_AW-1:0] RdIn,
`ifdef EX_FORWARD_EN
    input  logic [1:0]        FwdASel,
    input  logic [1:0]        FwdBSel,
    input  logic [DATA_W-1:0] FwdMemData,
    input  logic [DATA_W-1:0] FwdWbData,
`endif
    input  logic              Stall,
    input  logic              Flush,
    output logic              OutValid,
    output logic [DATA_W-1:0] ResultOut,
    output logic [DATA_W-1:0] DataOut,
    output logic [MEMC_W-1:0] MEMControlOut,
    output logic [WBC_W-1:0]  WBControlOut,
    output logic [REG_AW-1:0] RdOut,
    output logic              ZeroOut,
    output logic              OvfOut
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   sbData_q, sbData_d;
    logic [MEMC_W-1:0]   sbMem_q, sbMem_d;
    logic [WBC_W-1:0]    sbWb_q, sbWb_d;
    logic [REG_AW-1:0]   sbRd_q, sbRd_d;

    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MEMC_W-1:0]   mem_q, mem_d;
    logic [WBC_W-1:0]    wb_q, wb_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   fwdA, fwdB, opA, opB;
    logic [DATA_W-1:0]   sum, diff, aluRes, mulAddend;
    logic [REG_AW-1:0]   destReg;
    logic                aluOvf, slt, isMul, accept;
    logic                unusedCtrl;

`ifdef EX_FORWARD_EN
    always_comb begin
        fwdA = DataAIn;
        fwdB = DataBIn;
        case (FwdASel)
            2'b01:   fwdA = FwdMemData;
            2'b10:   fwdA = FwdWbData;
            default: fwdA = DataAIn;
        endcase
        case (FwdBSel)
            2'b01:   fwdB = FwdMemData;
            2'b10:   fwdB = FwdWbData;
            default: fwdB = DataBIn;
        endcase
    end
`else
    always_comb begin
        fwdA = DataAIn;
        fwdB = DataBIn;
    end
`endif

    assign opA        = fwdA;
    assign opB        = EXControlIn[3] ? SEIn : fwdB;
    assign destReg    = EXControlIn[0] ? RdIn : RtIn;
    assign unusedCtrl = ^EXControlIn[2:1];
    assign isMul      = (FunctIn == 3'b101);
    assign InReady    = (state_q == IDLE) && !Stall && !Rst;
    assign accept     = InValid && InReady && !Flush;

    assign sum  = opA + opB;
    assign diff = opA - opB;
    assign slt  = $signed(opA) < $signed(opB);
    assign mulAddend = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;

    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        case (FunctIn)
            3'b000: aluRes = opA & opB;
            3'b001: aluRes = opA | opB;
            3'b010: begin
                aluRes = sum;
                aluOvf = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]);
            end
            3'b011: aluRes = opA ^ opB;
            3'b100: aluRes = ~(opA | opB);
            3'b110: begin
                aluRes = diff;
                aluOvf = (opA[MSB] != opB[MSB]) && (diff[MSB] != opA[MSB]);
            end
            3'b111: aluRes = {{(DATA_W-1){1'b0}}, slt};
            default: aluRes = '0;
        endcase
    end

    // Flush overrides everything; otherwise the FSM decides what the EX/MEM register loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sbData_d = sbData_q;
        sbMem_d  = sbMem_q;
        sbWb_d   = sbWb_q;
        sbRd_d   = sbRd_q;
        valid_d  = valid_q;
        result_d = result_q;
        data_d   = data_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        rd_d     = rd_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (Flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && isMul) begin
                        mcand_d  = opA;
                        mplier_d = opB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        sbData_d = fwdB;
                        sbMem_d  = MEMControlIn;
                        sbWb_d   = WBControlIn;
                        sbRd_d   = destReg;
                        valid_d  = 1'b0;
                        state_d  = MUL;
                    end else if (accept) begin
                        valid_d  = 1'b1;
                        result_d = aluRes;
                        data_d   = fwdB;
                        mem_d    = MEMControlIn;
                        wb_d     = WBControlIn;
                        rd_d     = destReg;
                        zero_d   = (aluRes == '0);
                        ovf_d    = aluOvf;
                    end else if (!Stall) begin
                        valid_d = 1'b0;
                    end
                end
                MUL: begin
                    acc_d = acc_q + mulAddend;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!Stall) begin
                        valid_d  = 1'b1;
                        result_d = acc_q;
                        data_d   = sbData_q;
                        mem_d    = sbMem_q;
                        wb_d     = sbWb_q;
                        rd_d     = sbRd_q;
                        zero_d   = (acc_q == '0);
                        ovf_d    = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sbData_q <= '0;
            sbMem_q  <= '0;
            sbWb_q   <= '0;
            sbRd_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            data_q   <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            rd_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sbData_q <= sbData_d;
            sbMem_q  <= sbMem_d;
            sbWb_q   <= sbWb_d;
            sbRd_q   <= sbRd_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            data_q   <= data_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            rd_q     <= rd_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign OutValid      = valid_q;
    assign ResultOut     = result_q;
    assign DataOut       = data_q;
    assign MEMControlOut = mem_q;
    assign WBControlOut  = wb_q;
    assign RdOut         = rd_q;
    assign ZeroOut       = zero_q;
    assign OvfOut        = ovf_q;

endmodule
